// File: rtl/hazard_match_tracker.sv
// hazard_match_tracker
// Producer side of the hazard-control interface for the 5-stage ARM core.
// Tracks register addresses and write-type flags of the instructions in the
// Execute, Memory and Writeback stages, and derives the match vector and the
// status flags the hazard unit needs for forwarding, stalling and flushing.
module hazard_match_tracker #(
  parameter int RA_W   = 4,
  parameter int PC_REG = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] RA1D,
  input  logic [RA_W-1:0] RA2D,
  input  logic [RA_W-1:0] WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            PCSrcD,
  input  logic            BranchD,
  input  logic            CondExE,
  input  logic            FlushE,
  output logic [4:0]      match,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic            MemtoRegE,
  output logic            PCWrPendingF,
  output logic            PCSrcW,
  output logic            BranchTakenE
);

  localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

  // Execute-stage tracked state
  logic [RA_W-1:0] RA1E;
  logic [RA_W-1:0] RA2E;
  logic [RA_W-1:0] WA3E;
  logic            RegWriteE;
  logic            PCSrcE;
  logic            BranchE;

  // Memory-stage tracked state
  logic [RA_W-1:0] WA3M;
  logic            PCSrcM;

  // Writeback-stage tracked state
  logic [RA_W-1:0] WA3W;

  // Per-comparison qualifiers: a register equal to the PC never matches
  logic ra1d_ok;
  logic ra2d_ok;
  logic ra1e_ok;
  logic ra2e_ok;
  logic wa3e_ok;
  logic wa3m_ok;
  logic wa3w_ok;

  // D->E transfer; a flush loads an all-zero bubble into Execute
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      BranchE   <= 1'b0;
    end else begin
      RA1E      <= RA1D;
      RA2E      <= RA2D;
      WA3E      <= WA3D;
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      PCSrcE    <= PCSrcD;
      BranchE   <= BranchD;
    end
  end

  // E->M transfer; a condition-failed instruction becomes a non-writer in M
  always_ff @(posedge clk) begin
    if (reset) begin
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else begin
      WA3M      <= WA3E;
      RegWriteM <= RegWriteE & CondExE;
      PCSrcM    <= PCSrcE & CondExE;
    end
  end

  // M->W transfer, plain copy
  always_ff @(posedge clk) begin
    if (reset) begin
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      PCSrcW    <= PCSrcM;
    end
  end

  // PC-register exclusion for every address taking part in a comparison
  always_comb begin
    ra1d_ok = (RA1D != PC_IDX);
    ra2d_ok = (RA2D != PC_IDX);
    ra1e_ok = (RA1E != PC_IDX);
    ra2e_ok = (RA2E != PC_IDX);
    wa3e_ok = (WA3E != PC_IDX);
    wa3m_ok = (WA3M != PC_IDX);
    wa3w_ok = (WA3W != PC_IDX);
  end

  // Source/destination match vector; write-enable gating keeps bubbles silent
  always_comb begin
    match = 5'b00000;
    match[4] = (((RA1D == WA3E) & ra1d_ok) | ((RA2D == WA3E) & ra2d_ok))
               & RegWriteE & wa3e_ok;
    match[3] = (RA1E == WA3M) & ra1e_ok & RegWriteM & wa3m_ok;
    match[2] = (RA2E == WA3M) & ra2e_ok & RegWriteM & wa3m_ok;
    match[1] = (RA1E == WA3W) & ra1e_ok & RegWriteW & wa3w_ok;
    match[0] = (RA2E == WA3W) & ra2e_ok & RegWriteW & wa3w_ok;
  end

  // Control-flow status: E-stage PC write counted before its condition resolves
  always_comb begin
    PCWrPendingF = PCSrcD | PCSrcE | PCSrcM;
    BranchTakenE = BranchE & CondExE;
  end

endmodule

// File: tb/tb_hazard_match_tracker.sv
// Testbench for hazard_match_tracker: directed scenarios followed by random
// traffic, all compared against an instruction-level pipeline model.
module tb_hazard_match_tracker;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mr;
    logic       pcs;
    logic       br;
  } ins_t;

  logic       clk = 1'b0;
  ins_t       cur_d = '0;
  logic       cur_cond = 1'b0;
  logic       cur_flush = 1'b0;
  logic       cur_rst = 1'b1;

  logic [4:0] match;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE;

  // model: the instruction records currently held in E, M and W
  ins_t       mdl_e = '0;
  ins_t       mdl_m = '0;
  ins_t       mdl_w = '0;

  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  hazard_match_tracker #(.RA_W(4), .PC_REG(15)) dut (
    .clk          (clk),
    .reset        (cur_rst),
    .RA1D         (cur_d.ra1),
    .RA2D         (cur_d.ra2),
    .WA3D         (cur_d.wa3),
    .RegWriteD    (cur_d.rw),
    .MemtoRegD    (cur_d.mr),
    .PCSrcD       (cur_d.pcs),
    .BranchD      (cur_d.br),
    .CondExE      (cur_cond),
    .FlushE       (cur_flush),
    .match        (match),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCWrPendingF (PCWrPendingF),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a reader hits a writer when the addresses agree and neither is the PC
  function automatic logic hit(input logic [3:0] ra, input logic [3:0] wa, input logic wr);
    return wr && (ra == wa) && (ra != 4'd15) && (wa != 4'd15);
  endfunction

  task automatic drive(input ins_t d, input logic cond, input logic flush, input logic rst);
    @(negedge clk);
    cur_d     = d;
    cur_cond  = cond;
    cur_flush = flush;
    cur_rst   = rst;
    #1;
  endtask

  task automatic check_model();
    logic [4:0] em;
    em[4] = hit(cur_d.ra1, mdl_e.wa3, mdl_e.rw) | hit(cur_d.ra2, mdl_e.wa3, mdl_e.rw);
    em[3] = hit(mdl_e.ra1, mdl_m.wa3, mdl_m.rw);
    em[2] = hit(mdl_e.ra2, mdl_m.wa3, mdl_m.rw);
    em[1] = hit(mdl_e.ra1, mdl_w.wa3, mdl_w.rw);
    em[0] = hit(mdl_e.ra2, mdl_w.wa3, mdl_w.rw);
    chk("match",        32'(match),        32'(em));
    chk("RegWriteM",    32'(RegWriteM),    32'(mdl_m.rw));
    chk("RegWriteW",    32'(RegWriteW),    32'(mdl_w.rw));
    chk("MemtoRegE",    32'(MemtoRegE),    32'(mdl_e.mr));
    chk("PCWrPendingF", 32'(PCWrPendingF), 32'(cur_d.pcs | mdl_e.pcs | mdl_m.pcs));
    chk("PCSrcW",       32'(PCSrcW),       32'(mdl_w.pcs));
    chk("BranchTakenE", 32'(BranchTakenE), 32'(mdl_e.br & cur_cond));
  endtask

  // advance the instruction records one stage at the clock edge
  task automatic tick();
    ins_t ne, nm, nw;
    @(posedge clk);
    nw = mdl_m;
    nm = mdl_e;
    nm.rw  = mdl_e.rw & cur_cond;
    nm.pcs = mdl_e.pcs & cur_cond;
    ne = cur_flush ? ins_t'(0) : cur_d;
    if (cur_rst) begin
      ne = '0;
      nm = '0;
      nw = '0;
    end
    mdl_e = ne;
    mdl_m = nm;
    mdl_w = nw;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r;
    r.ra1 = rnd_reg();
    r.ra2 = rnd_reg();
    r.wa3 = rnd_reg();
    r.rw  = 1'($urandom_range(0, 1));
    r.mr  = 1'($urandom_range(0, 1));
    r.pcs = ($urandom_range(0, 5) == 0);
    r.br  = ($urandom_range(0, 4) == 0);
    return r;
  endfunction

  function automatic ins_t mk(input int ra1, input int ra2, input int wa3,
                              input bit rw, input bit mr, input bit pcs, input bit br);
    ins_t r;
    r.ra1 = 4'(ra1);
    r.ra2 = 4'(ra2);
    r.wa3 = 4'(wa3);
    r.rw  = rw;
    r.mr  = mr;
    r.pcs = pcs;
    r.br  = br;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, use_i;
    nop = '0;

    // reset for two cycles with random D inputs
    drive(rnd_ins(), 1'b1, 1'b0, 1'b1);
    tick();
    drive(rnd_ins(), 1'b1, 1'b0, 1'b1);
    check_model();
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_flags", 32'({RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCSrcW}), 32'd0);
    tick();

    // ALU forwarding from M then W
    drive(mk(1, 2, 3, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(mk(3, 4, 6, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(mk(7, 3, 8, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    chk("fwd_m_match3", 32'(match[3]), 32'd1);
    chk("fwd_m_regwm", 32'(RegWriteM), 32'd1);
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("fwd_w_match0", 32'(match[0]), 32'd1);
    chk("fwd_w_regww", 32'(RegWriteW), 32'd1);
    tick();

    // load-use, then a flush bubble while D is held
    drive(mk(0, 0, 2, 1, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    use_i = mk(9, 2, 10, 1, 0, 0, 0);
    drive(use_i, 1'b1, 1'b1, 1'b0);
    check_model();
    chk("ldu_match4", 32'(match[4]), 32'd1);
    chk("ldu_memtoreg", 32'(MemtoRegE), 32'd1);
    tick();
    drive(use_i, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("bubble_memtoreg", 32'(MemtoRegE), 32'd0);
    chk("bubble_match4", 32'(match[4]), 32'd0);
    tick();

    // condition-failed producer does not write
    drive(mk(1, 1, 5, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(mk(5, 0, 11, 1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
    check_model();
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("cfail_regwm", 32'(RegWriteM), 32'd0);
    chk("cfail_match3", 32'(match[3]), 32'd0);
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("cfail_regww", 32'(RegWriteW), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(nop, 1'b1, 1'b0, 1'b0);
      check_model();
      tick();
    end

    // PC write in flight through D, E, M, then lands in W
    drive(mk(0, 0, 15, 1, 0, 1, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    chk("pcw_pend_d", 32'(PCWrPendingF), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(nop, 1'b1, 1'b0, 1'b0);
      check_model();
      chk("pcw_pend_em", 32'(PCWrPendingF), 32'd1);
      tick();
    end
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("pcw_pend_off", 32'(PCWrPendingF), 32'd0);
    chk("pcw_srcw", 32'(PCSrcW), 32'd1);
    tick();

    // taken branch for exactly one cycle
    drive(mk(0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("br_taken", 32'(BranchTakenE), 32'd1);
    tick();
    drive(nop, 1'b1, 1'b0, 1'b0);
    check_model();
    chk("br_once", 32'(BranchTakenE), 32'd0);
    tick();

    // PC as source and destination never matches
    drive(mk(0, 0, 15, 1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(mk(15, 1, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    chk("pc_src_match4", 32'(match[4]), 32'd0);
    tick();

    // mid-stream reset discards in-flight state
    drive(mk(1, 2, 3, 1, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    check_model();
    tick();
    drive(mk(3, 3, 4, 1, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    check_model();
    tick();
    drive(mk(4, 3, 0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    check_model();
    chk("midrst_match", 32'(match), 32'd0);
    chk("midrst_memtoreg", 32'(MemtoRegE), 32'd0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(rnd_ins(), 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 49) == 0));
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_match_tracker.md
Name: hazard_match_tracker

Overview:
- Producer side of the hazard-control interface for the 5-stage pipelined ARM core. It tracks source and destination register addresses and write-type flags of the instructions in the Execute, Memory and Writeback stages.
- From that state it generates the match[4:0] vector, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW and BranchTakenE, which feed the hazard unit.
- The FlushE request is fed back from the hazard unit and inserts bubbles into the tracked Execute stage.

Parameters:
- RA_W, 4, register address width (R0..R15).
- PC_REG, 15, register index of the PC. A source or destination equal to PC_REG never produces a match.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all tracked stage state
- RA1D  input  RA_W  first source register of the Decode-stage instruction
- RA2D  input  RA_W  second source register of the Decode-stage instruction
- WA3D  input  RA_W  destination register of the Decode-stage instruction
- RegWriteD  input  1  Decode instruction writes the register file
- MemtoRegD  input  1  Decode instruction is a load (LDR)
- PCSrcD  input  1  Decode instruction writes the PC (register write to PC_REG)
- BranchD  input  1  Decode instruction is a B/BL
- CondExE  input  1  condition check passed for the instruction now in Execute
- FlushE  input  1  bubble the Decode->Execute transfer (from hazard unit)
- match  output  5  [4]=RA1D/RA2D vs WA3E, [3]=RA1E vs WA3M, [2]=RA2E vs WA3M, [1]=RA1E vs WA3W, [0]=RA2E vs WA3W
- RegWriteM  output  1  Memory-stage instruction will write the register file
- RegWriteW  output  1  Writeback-stage instruction writes the register file
- MemtoRegE  output  1  Execute-stage instruction is a load
- PCWrPendingF  output  1  PC write in flight in D, E or M
- PCSrcW  output  1  Writeback-stage instruction writes the PC
- BranchTakenE  output  1  Execute-stage branch whose condition passed

Behaviour:
- Internal registers:
  - E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE, BranchE.
  - M stage: WA3M, RegWriteM, PCSrcM.
  - W stage: WA3W, RegWriteW, PCSrcW.
- Reset, synchronous: every internal register is cleared to 0 on the first rising edge with reset=1. Outputs after that edge:
  - match=5'b00000, RegWriteM=0, RegWriteW=0, MemtoRegE=0, PCWrPendingF=PCSrcD, PCSrcW=0, BranchTakenE=0.
  - reset asserted mid-stream discards all in-flight stage state on that edge.
- D->E transfer, each edge:
  - FlushE=1: E flags (RegWriteE, MemtoRegE, PCSrcE, BranchE) are loaded with 0 and addresses with 0 (bubble).
  - Otherwise E loads the D inputs.
  - No stall input: on StallD, upstream holds the D inputs stable.
- E->M transfer, each edge:
  - RegWriteM <= RegWriteE & CondExE; PCSrcM <= PCSrcE & CondExE; WA3M <= WA3E.
  - A condition-failed instruction becomes a non-writing instruction in M.
- M->W transfer, each edge: unconditional copy of WA3M, RegWriteM, PCSrcM.
- A flush and a valid E instruction in the same cycle: the E->M transfer uses the old E contents; the flush affects only the new E contents.
- match bits, combinational from the registered state (match[4] also from RA1D/RA2D):
  - match[4] = ((RA1D==WA3E) | (RA2D==WA3E)) & RegWriteE & (WA3E!=PC_REG), with each RAxD term also requiring RAxD!=PC_REG.
  - match[3:2] compare RA1E/RA2E against WA3M, gated by RegWriteM & WA3M!=PC_REG & RAxE!=PC_REG.
  - match[1:0] do the same against WA3W, gated by RegWriteW.
  - Gating guarantees all-zero matches after reset, on bubbles and on PC-source reads.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM, combinational. PCSrcE is ungated by CondExE (conservative).
- BranchTakenE = BranchE & CondExE, combinational.
- Latency: a D-stage destination appears as WA3E one edge later, as WA3M two edges later and as WA3W three edges later.

Test Plan:
- Reset: reset=1 for 2 cycles with random D inputs -> after release, match=0, RegWriteM=RegWriteW=MemtoRegE=BranchTakenE=PCSrcW=0.
- ALU forward from M and W: ADD R3 (WA3D=3, RegWriteD=1), then SUB with RA1D=3, then ORR with RA2D=3, CondExE=1 -> the SUB in E sees match[3]=1 and RegWriteM=1; one cycle later the ORR in E sees match[0]=1 and RegWriteW=1.
- Load-use: LDR R2 (MemtoRegD=1, WA3D=2), next RA2D=2 -> match[4]=1 and MemtoRegE=1. Apply FlushE=1 for one edge -> next cycle E is a bubble: MemtoRegE=0 and match[4] drops to 0 while the D inputs are held.
- Condition fail: ADD R5 with CondExE=0 while in E, consumer has RA1E=5 -> RegWriteM=0 and match[3]=0. RegWriteW=0 one cycle later.
- PC write in flight: PCSrcD=1 for one cycle, then zeros -> PCWrPendingF=1 for 3 consecutive cycles (D, E, M), then 0; PCSrcW=1 on the 4th cycle when CondExE=1.
- Branch and PC source: BranchD=1 then CondExE=1 -> BranchTakenE=1 for exactly one cycle. A source RA1D=15 with WA3E=15 and RegWriteE=1 -> match[4]=0.
